// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: opcode and FSM state encodings shared by alu_iter and its datapath.
// Revision 1.0
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_NAND = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ROR  = 4'h6,
    OP_ROL  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_MUL  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_ROR) || (op == OP_ROL) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_comb.sv
`default_nettype none
// alu_iter_comb: single-cycle ALU ops plus one bit-step of a shift/rotate.
// Revision 1.0
module alu_iter_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sc_i,
  output logic [WIDTH-1:0] res_o,
  output logic             sc_o,
  output logic             ill_o,
  input  logic [OP_W-1:0]  step_op_i,
  input  logic [WIDTH-1:0] step_d_i,
  input  logic             step_sc_i,
  output logic [WIDTH-1:0] step_d_o,
  output logic             step_sc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, sc_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Shift/rotate ops land here only with amount 0: operand passes through.
  always_comb begin
    res_o = '0;
    sc_o  = 1'b0;
    ill_o = 1'b0;
    case (op_i)
      OP_ADD:  begin res_o = sum[WIDTH-1:0];  sc_o = sum[WIDTH];   end
      OP_SUB:  begin res_o = diff[WIDTH-1:0]; sc_o = ~diff[WIDTH]; end
      OP_AND:  res_o = a_i & b_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_ROR, OP_ROL, OP_SHL, OP_SHR: res_o = a_i;
      default: ill_o = 1'b1;
    endcase
  end

  always_comb begin
    step_d_o  = step_d_i;
    step_sc_o = 1'b0;
    case (step_op_i)
      OP_ROR: step_d_o = {step_d_i[0], step_d_i[WIDTH-1:1]};
      OP_ROL: step_d_o = {step_d_i[WIDTH-2:0], step_d_i[WIDTH-1]};
      OP_SHL: begin
        step_d_o  = {step_d_i[WIDTH-2:0], step_sc_i};
        step_sc_o = step_d_i[WIDTH-1];
      end
      OP_SHR: begin
        step_d_o  = {step_sc_i, step_d_i[WIDTH-1:1]};
        step_sc_o = step_d_i[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// alu_iter: clocked ALU with iterative shifts/rotates and valid/ready handshakes.
// Optional shift-add multiply on op A when ALU_ITER_MUL_EN is defined. Revision 1.0
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             zero,
  output logic             neq,
  output logic             ill
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  state_e             state_q;
  logic [OP_W-1:0]    op_q;
  logic               sc_q;
  logic [WIDTH-1:0]   work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   rslt_q;
  logic               sc_o_q;
  logic               zero_q;
  logic               pari_q;
  logic               neq_q;
  logic               ill_q;

  logic [WIDTH-1:0]   single_res;
  logic               single_sc;
  logic               single_ill;
  logic [WIDTH-1:0]   step_res;
  logic               step_sc;
  logic [SHAMT_W-1:0] shamt;
  logic               start_mul;
  logic               start_exec;
  logic               finish;
  logic [WIDTH-1:0]   rslt_d;
  logic               sc_d;
  logic               ill_d;

  assign shamt = in_b[SHAMT_W-1:0];

  alu_iter_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i      (op),
    .a_i       (in_a),
    .b_i       (in_b),
    .sc_i      (sc_i),
    .res_o     (single_res),
    .sc_o      (single_sc),
    .ill_o     (single_ill),
    .step_op_i (op_q),
    .step_d_i  (work_q),
    .step_sc_i (sc_q),
    .step_d_o  (step_res),
    .step_sc_o (step_sc)
  );

`ifdef ALU_ITER_MUL_EN
  // Product register: high half accumulates, low half holds the multiplier shifting out.
  logic [2*WIDTH-1:0] mul_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;

  assign mul_sum   = {1'b0, mul_q[2*WIDTH-1:WIDTH]} + (mul_q[0] ? {1'b0, work_q} : '0);
  assign mul_d     = {mul_sum, mul_q[WIDTH-1:1]};
  assign start_mul = (op == OP_MUL);
`else
  assign start_mul = 1'b0;
`endif

  assign start_exec = start_mul || (is_shift(op) && (shamt != '0));
  assign finish     = ((state_q == IDLE) && in_valid && !start_exec) ||
                      ((state_q == EXEC) && (cnt_q == CNT_W'(1)));

  always_comb begin
    rslt_d = single_res;
    sc_d   = single_sc;
    ill_d  = single_ill;
    if (state_q == EXEC) begin
      rslt_d = step_res;
      sc_d   = step_sc;
      ill_d  = 1'b0;
`ifdef ALU_ITER_MUL_EN
      if (op_q == OP_MUL) begin
        rslt_d = mul_d[WIDTH-1:0];
        sc_d   = |mul_d[2*WIDTH-1:WIDTH];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sc_q        <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      rslt_q      <= '0;
      sc_o_q      <= 1'b0;
      zero_q      <= 1'b1;
      pari_q      <= 1'b0;
      neq_q       <= 1'b0;
      ill_q       <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      mul_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            sc_q       <= sc_i;
            work_q     <= in_a;
            neq_q      <= (in_a != in_b);
            in_ready_q <= 1'b0;
`ifdef ALU_ITER_MUL_EN
            mul_q      <= {{WIDTH{1'b0}}, in_b};
`endif
            if (start_exec) begin
              state_q <= EXEC;
              cnt_q   <= start_mul ? CNT_W'(WIDTH) : {1'b0, shamt};
            end
          end
        end
        EXEC: begin
          work_q <= step_res;
          cnt_q  <= cnt_q - 1'b1;
`ifdef ALU_ITER_MUL_EN
          mul_q  <= mul_d;
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (finish) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        rslt_q      <= rslt_d;
        sc_o_q      <= sc_d;
        ill_q       <= ill_d;
        zero_q      <= (rslt_d == '0);
        pari_q      <= ^rslt_d;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rslt      = rslt_q;
  assign sc_o      = sc_o_q;
  assign zero      = zero_q;
  assign pari      = pari_q;
  assign neq       = neq_q;
  assign ill       = ill_q;

endmodule
`default_nettype wire
